// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared types and helpers for the AES datapath blocks.
//   aes_block_t      : one 128-bit AES state, column-major. Byte i = 4*col+row
//                      sits at bits [127-8i -: 8], so [127:120] is row0/col0.
//   subbytes_state_e : control states of the column-serial SubBytes engine.
//   byte_lsb()       : (row, col) -> LSB bit position of that byte in a block.
// ----------------------------------------------------------------------------
package aes_pkg;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } subbytes_state_e;

    // Byte (row, col) occupies bits [lsb+7:lsb], lsb = 120 - 32*col - 8*row.
    function automatic logic [6:0] byte_lsb(input logic [1:0] row, input logic [1:0] col);
        return 7'd120 - {col, 5'b0} - {2'b0, row, 3'b0};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ----------------------------------------------------------------------------
// aes_sbox
// Forward AES S-box as a combinational 256-entry lookup table.
//   a : input byte
//   c : substituted byte
// ----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] c
);

    always_comb begin
        c = 8'h00;
        case (a)
            8'h00: c = 8'h63; 8'h01: c = 8'h7c; 8'h02: c = 8'h77; 8'h03: c = 8'h7b; 8'h04: c = 8'hf2; 8'h05: c = 8'h6b; 8'h06: c = 8'h6f; 8'h07: c = 8'hc5;
            8'h08: c = 8'h30; 8'h09: c = 8'h01; 8'h0a: c = 8'h67; 8'h0b: c = 8'h2b; 8'h0c: c = 8'hfe; 8'h0d: c = 8'hd7; 8'h0e: c = 8'hab; 8'h0f: c = 8'h76;
            8'h10: c = 8'hca; 8'h11: c = 8'h82; 8'h12: c = 8'hc9; 8'h13: c = 8'h7d; 8'h14: c = 8'hfa; 8'h15: c = 8'h59; 8'h16: c = 8'h47; 8'h17: c = 8'hf0;
            8'h18: c = 8'had; 8'h19: c = 8'hd4; 8'h1a: c = 8'ha2; 8'h1b: c = 8'haf; 8'h1c: c = 8'h9c; 8'h1d: c = 8'ha4; 8'h1e: c = 8'h72; 8'h1f: c = 8'hc0;
            8'h20: c = 8'hb7; 8'h21: c = 8'hfd; 8'h22: c = 8'h93; 8'h23: c = 8'h26; 8'h24: c = 8'h36; 8'h25: c = 8'h3f; 8'h26: c = 8'hf7; 8'h27: c = 8'hcc;
            8'h28: c = 8'h34; 8'h29: c = 8'ha5; 8'h2a: c = 8'he5; 8'h2b: c = 8'hf1; 8'h2c: c = 8'h71; 8'h2d: c = 8'hd8; 8'h2e: c = 8'h31; 8'h2f: c = 8'h15;
            8'h30: c = 8'h04; 8'h31: c = 8'hc7; 8'h32: c = 8'h23; 8'h33: c = 8'hc3; 8'h34: c = 8'h18; 8'h35: c = 8'h96; 8'h36: c = 8'h05; 8'h37: c = 8'h9a;
            8'h38: c = 8'h07; 8'h39: c = 8'h12; 8'h3a: c = 8'h80; 8'h3b: c = 8'he2; 8'h3c: c = 8'heb; 8'h3d: c = 8'h27; 8'h3e: c = 8'hb2; 8'h3f: c = 8'h75;
            8'h40: c = 8'h09; 8'h41: c = 8'h83; 8'h42: c = 8'h2c; 8'h43: c = 8'h1a; 8'h44: c = 8'h1b; 8'h45: c = 8'h6e; 8'h46: c = 8'h5a; 8'h47: c = 8'ha0;
            8'h48: c = 8'h52; 8'h49: c = 8'h3b; 8'h4a: c = 8'hd6; 8'h4b: c = 8'hb3; 8'h4c: c = 8'h29; 8'h4d: c = 8'he3; 8'h4e: c = 8'h2f; 8'h4f: c = 8'h84;
            8'h50: c = 8'h53; 8'h51: c = 8'hd1; 8'h52: c = 8'h00; 8'h53: c = 8'hed; 8'h54: c = 8'h20; 8'h55: c = 8'hfc; 8'h56: c = 8'hb1; 8'h57: c = 8'h5b;
            8'h58: c = 8'h6a; 8'h59: c = 8'hcb; 8'h5a: c = 8'hbe; 8'h5b: c = 8'h39; 8'h5c: c = 8'h4a; 8'h5d: c = 8'h4c; 8'h5e: c = 8'h58; 8'h5f: c = 8'hcf;
            8'h60: c = 8'hd0; 8'h61: c = 8'hef; 8'h62: c = 8'haa; 8'h63: c = 8'hfb; 8'h64: c = 8'h43; 8'h65: c = 8'h4d; 8'h66: c = 8'h33; 8'h67: c = 8'h85;
            8'h68: c = 8'h45; 8'h69: c = 8'hf9; 8'h6a: c = 8'h02; 8'h6b: c = 8'h7f; 8'h6c: c = 8'h50; 8'h6d: c = 8'h3c; 8'h6e: c = 8'h9f; 8'h6f: c = 8'ha8;
            8'h70: c = 8'h51; 8'h71: c = 8'ha3; 8'h72: c = 8'h40; 8'h73: c = 8'h8f; 8'h74: c = 8'h92; 8'h75: c = 8'h9d; 8'h76: c = 8'h38; 8'h77: c = 8'hf5;
            8'h78: c = 8'hbc; 8'h79: c = 8'hb6; 8'h7a: c = 8'hda; 8'h7b: c = 8'h21; 8'h7c: c = 8'h10; 8'h7d: c = 8'hff; 8'h7e: c = 8'hf3; 8'h7f: c = 8'hd2;
            8'h80: c = 8'hcd; 8'h81: c = 8'h0c; 8'h82: c = 8'h13; 8'h83: c = 8'hec; 8'h84: c = 8'h5f; 8'h85: c = 8'h97; 8'h86: c = 8'h44; 8'h87: c = 8'h17;
            8'h88: c = 8'hc4; 8'h89: c = 8'ha7; 8'h8a: c = 8'h7e; 8'h8b: c = 8'h3d; 8'h8c: c = 8'h64; 8'h8d: c = 8'h5d; 8'h8e: c = 8'h19; 8'h8f: c = 8'h73;
            8'h90: c = 8'h60; 8'h91: c = 8'h81; 8'h92: c = 8'h4f; 8'h93: c = 8'hdc; 8'h94: c = 8'h22; 8'h95: c = 8'h2a; 8'h96: c = 8'h90; 8'h97: c = 8'h88;
            8'h98: c = 8'h46; 8'h99: c = 8'hee; 8'h9a: c = 8'hb8; 8'h9b: c = 8'h14; 8'h9c: c = 8'hde; 8'h9d: c = 8'h5e; 8'h9e: c = 8'h0b; 8'h9f: c = 8'hdb;
            8'ha0: c = 8'he0; 8'ha1: c = 8'h32; 8'ha2: c = 8'h3a; 8'ha3: c = 8'h0a; 8'ha4: c = 8'h49; 8'ha5: c = 8'h06; 8'ha6: c = 8'h24; 8'ha7: c = 8'h5c;
            8'ha8: c = 8'hc2; 8'ha9: c = 8'hd3; 8'haa: c = 8'hac; 8'hab: c = 8'h62; 8'hac: c = 8'h91; 8'had: c = 8'h95; 8'hae: c = 8'he4; 8'haf: c = 8'h79;
            8'hb0: c = 8'he7; 8'hb1: c = 8'hc8; 8'hb2: c = 8'h37; 8'hb3: c = 8'h6d; 8'hb4: c = 8'h8d; 8'hb5: c = 8'hd5; 8'hb6: c = 8'h4e; 8'hb7: c = 8'ha9;
            8'hb8: c = 8'h6c; 8'hb9: c = 8'h56; 8'hba: c = 8'hf4; 8'hbb: c = 8'hea; 8'hbc: c = 8'h65; 8'hbd: c = 8'h7a; 8'hbe: c = 8'hae; 8'hbf: c = 8'h08;
            8'hc0: c = 8'hba; 8'hc1: c = 8'h78; 8'hc2: c = 8'h25; 8'hc3: c = 8'h2e; 8'hc4: c = 8'h1c; 8'hc5: c = 8'ha6; 8'hc6: c = 8'hb4; 8'hc7: c = 8'hc6;
            8'hc8: c = 8'he8; 8'hc9: c = 8'hdd; 8'hca: c = 8'h74; 8'hcb: c = 8'h1f; 8'hcc: c = 8'h4b; 8'hcd: c = 8'hbd; 8'hce: c = 8'h8b; 8'hcf: c = 8'h8a;
            8'hd0: c = 8'h70; 8'hd1: c = 8'h3e; 8'hd2: c = 8'hb5; 8'hd3: c = 8'h66; 8'hd4: c = 8'h48; 8'hd5: c = 8'h03; 8'hd6: c = 8'hf6; 8'hd7: c = 8'h0e;
            8'hd8: c = 8'h61; 8'hd9: c = 8'h35; 8'hda: c = 8'h57; 8'hdb: c = 8'hb9; 8'hdc: c = 8'h86; 8'hdd: c = 8'hc1; 8'hde: c = 8'h1d; 8'hdf: c = 8'h9e;
            8'he0: c = 8'he1; 8'he1: c = 8'hf8; 8'he2: c = 8'h98; 8'he3: c = 8'h11; 8'he4: c = 8'h69; 8'he5: c = 8'hd9; 8'he6: c = 8'h8e; 8'he7: c = 8'h94;
            8'he8: c = 8'h9b; 8'he9: c = 8'h1e; 8'hea: c = 8'h87; 8'heb: c = 8'he9; 8'hec: c = 8'hce; 8'hed: c = 8'h55; 8'hee: c = 8'h28; 8'hef: c = 8'hdf;
            8'hf0: c = 8'h8c; 8'hf1: c = 8'ha1; 8'hf2: c = 8'h89; 8'hf3: c = 8'h0d; 8'hf4: c = 8'hbf; 8'hf5: c = 8'he6; 8'hf6: c = 8'h42; 8'hf7: c = 8'h68;
            8'hf8: c = 8'h41; 8'hf9: c = 8'h99; 8'hfa: c = 8'h2d; 8'hfb: c = 8'h0f; 8'hfc: c = 8'hb0; 8'hfd: c = 8'h54; 8'hfe: c = 8'hbb; 8'hff: c = 8'h16;
            default: c = 8'h00;
        endcase
    end

endmodule

// File: rtl/subbytes_seq.sv
// ----------------------------------------------------------------------------
// subbytes_seq
// Column-serial forward AES SubBytes engine. Accepts one 128-bit state over a
// valid/ready handshake, substitutes one 32-bit column per cycle through four
// S-boxes, and holds the result on a valid/ready output until taken.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : in_data valid
//   in_ready  : block accepts in_data this cycle (combinational from out_ready)
//   in_data   : input state, column-major, [127:120] = row0/col0
//   out_valid : out_data valid (held until out_ready)
//   out_ready : downstream accepts out_data
//   out_data  : substituted state, driven straight from the state register
//   busy      : high while columns are being substituted
//
// Build option: define SUBBYTES_SHIFTROWS_EN to fold ShiftRows into the
// output wiring (no added latency). Undefined: plain SubBytes result.
// ----------------------------------------------------------------------------
module subbytes_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    subbytes_state_e state_reg;
    logic [1:0]      col_reg;
    aes_block_t      data_reg;
    aes_block_t      data_next;
    logic            out_valid_reg;
    logic            busy_reg;

    logic [31:0]     col_word;
    logic [31:0]     sub_word;

    genvar gi;

    // Select the column currently being substituted.
    always_comb begin
        col_word = data_reg[31:0];
        case (col_reg)
            2'd0:    col_word = data_reg[127:96];
            2'd1:    col_word = data_reg[95:64];
            2'd2:    col_word = data_reg[63:32];
            default: col_word = data_reg[31:0];
        endcase
    end

    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .a (col_word[31-8*gi -: 8]),
                .c (sub_word[31-8*gi -: 8])
            );
        end
    endgenerate

    // State register with the active column replaced by its substitution.
    always_comb begin
        data_next = data_reg;
        case (col_reg)
            2'd0:    data_next[127:96] = sub_word;
            2'd1:    data_next[95:64]  = sub_word;
            2'd2:    data_next[63:32]  = sub_word;
            default: data_next[31:0]   = sub_word;
        endcase
    end

    // DONE with out_ready high frees the register this very edge, so a new
    // block can be taken without a bubble cycle through IDLE.
    assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            col_reg       <= 2'd0;
            data_reg      <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        data_reg  <= in_data;
                        col_reg   <= 2'd0;
                        state_reg <= BUSY;
                        busy_reg  <= 1'b1;
                    end
                end
                BUSY: begin
                    data_reg <= data_next;
                    col_reg  <= col_reg + 2'd1;
                    if (col_reg == 2'd3) begin
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (in_valid) begin
                            data_reg  <= in_data;
                            col_reg   <= 2'd0;
                            state_reg <= BUSY;
                            busy_reg  <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    col_reg       <= 2'd0;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;

`ifdef SUBBYTES_SHIFTROWS_EN
    // Output byte (row r, col c) takes state byte (row r, col (c+r) mod 4).
    generate
        for (gi = 0; gi < 16; gi++) begin : g_shift
            localparam logic [1:0] dst_row = 2'(gi % 4);
            localparam logic [1:0] dst_col = 2'(gi / 4);
            localparam logic [1:0] src_col = 2'((gi / 4 + gi % 4) % 4);
            localparam int dst_lsb = int'(byte_lsb(dst_row, dst_col));
            localparam int src_lsb = int'(byte_lsb(dst_row, src_col));
            assign out_data[dst_lsb +: 8] = data_reg[src_lsb +: 8];
        end
    endgenerate
`else
    assign out_data = data_reg;
`endif

endmodule

// File: tb/tb_subbytes_seq.sv
module tb_subbytes_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox_tab [256];

    subbytes_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (a^254) then the affine map.
    function automatic logic [7:0] sbox_model(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] expected_block(input logic [127:0] blk);
        logic [7:0]   s [16];
        logic [7:0]   o [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = sbox_tab[blk[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
`ifdef SUBBYTES_SHIFTROWS_EN
                o[4*c+r] = s[4*((c+r)%4)+r];
`else
                o[4*c+r] = s[4*c+r];
`endif
            end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
        return res;
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- drivers ----------------
    // Present a block and return at the falling edge after it was accepted.
    task automatic accept_block(input logic [127:0] d);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0 required 1 within 50 cycles");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count falling edges until out_valid; latency 4 means edge N+4.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_zero();
        int lat;
        out_ready = 1'b1;
        accept_block(128'h0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b required 1", busy); end
        wait_out(lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL zero_latency: got %0d required 4", lat); end
        checks++; if (out_data !== {4{32'h63636363}}) begin errors++; $display("FAIL zero_data: got %h required %h", out_data, {4{32'h63636363}}); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL zero_release: got valid=%b ready=%b required valid=0 ready=1", out_valid, in_ready); end
        $display("test_zero lat=%0d data=%h", lat, out_data);
    endtask

    task automatic test_fips();
        int lat;
        logic [127:0] vec;
        logic [127:0] want;
        vec = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
`ifdef SUBBYTES_SHIFTROWS_EN
        want = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
`else
        want = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
`endif
        out_ready = 1'b1;
        accept_block(vec);
        wait_out(lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL fips_latency: got %0d required 4", lat); end
        checks++; if (out_data !== want) begin errors++; $display("FAIL fips_data: got %h required %h", out_data, want); end
        checks++; if (out_data !== expected_block(vec)) begin errors++; $display("FAIL fips_model: got %h required %h", out_data, expected_block(vec)); end
        @(negedge clk);
        $display("test_fips out=%h", want);
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] d1;
        logic [127:0] d2;
        logic [127:0] e1;
        d1 = rand_block();
        d2 = rand_block();
        e1 = expected_block(d1);
        out_ready = 1'b0;
        accept_block(d1);
        wait_out(lat);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: got %b required 1", out_valid); end
        in_valid = 1'b1;
        in_data  = d2;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (out_data !== e1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall_%0d: got data=%h valid=%b ready=%b required data=%h valid=1 ready=0", i, out_data, out_valid, in_ready, e1);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb: got %b required 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_same_edge_accept: got busy=%b valid=%b required busy=1 valid=0", busy, out_valid); end
        wait_out(lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL bp_next_latency: got %0d required 4", lat); end
        checks++; if (out_data !== expected_block(d2)) begin errors++; $display("FAIL bp_next_data: got %h required %h", out_data, expected_block(d2)); end
        @(negedge clk);
        $display("test_backpressure d1=%h d2=%h", d1, d2);
    endtask

    task automatic test_back_to_back();
        logic [127:0] d [3];
        logic [127:0] e [3];
        int idx_in;
        int got;
        int cyc;
        int last_hs;
        bit acc;
        bit hs;
        for (int i = 0; i < 3; i++) begin
            d[i] = rand_block();
            e[i] = expected_block(d[i]);
        end
        out_ready = 1'b1;
        idx_in    = 0;
        got       = 0;
        last_hs   = -1;
        in_valid  = 1'b1;
        in_data   = d[0];
        for (cyc = 0; cyc < 60 && got < 3; cyc++) begin
            #1;
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                checks++;
                if (out_data !== e[got]) begin errors++; $display("FAIL b2b_data_%0d: got %h required %h", got, out_data, e[got]); end
                if (got > 0) begin
                    checks++;
                    if (cyc - last_hs != 5) begin errors++; $display("FAIL b2b_spacing_%0d: got %0d required 5", got, cyc - last_hs); end
                end
                $display("test_back_to_back out%0d cycle=%0d data=%h", got, cyc, out_data);
                last_hs = cyc;
                got++;
            end
            @(negedge clk);
            if (acc) begin
                idx_in++;
                if (idx_in < 3) in_data = d[idx_in];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 3) begin errors++; $display("FAIL b2b_count: got %0d required 3", got); end
    endtask

    task automatic test_mid_reset();
        int lat;
        bit seen;
        logic [127:0] d;
        out_ready = 1'b1;
        accept_block(rand_block());
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b required 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 128'h0) begin
            errors++;
            $display("FAIL midrst_values: got valid=%b busy=%b ready=%b data=%h required 0,0,1,0", out_valid, busy, in_ready, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL midrst_no_valid: got out_valid=1 required 0"); end
        d = rand_block();
        accept_block(d);
        wait_out(lat);
        checks++; if (lat != 4 || out_data !== expected_block(d)) begin errors++; $display("FAIL midrst_next: got lat=%0d data=%h required lat=4 data=%h", lat, out_data, expected_block(d)); end
        @(negedge clk);
        $display("test_mid_reset next=%h", d);
    endtask

    // Sixteen blocks covering every byte value once.
    task automatic test_sbox_sweep();
        int lat;
        logic [127:0] d;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) d[127-8*i -: 8] = 8'(16*k + i);
            accept_block(d);
            wait_out(lat);
            checks++;
            if (out_data !== expected_block(d)) begin errors++; $display("FAIL sweep_%0d: got %h required %h", k, out_data, expected_block(d)); end
            $display("test_sbox_sweep blk=%0d in=%h out=%h", k, d, out_data);
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int lat;
        int stall;
        logic [127:0] d;
        logic [127:0] e;
        for (int k = 0; k < 10; k++) begin
            d = rand_block();
            e = expected_block(d);
            out_ready = 1'b0;
            accept_block(d);
            wait_out(lat);
            stall = int'($urandom_range(0, 3));
            for (int s = 0; s < stall; s++) @(negedge clk);
            checks++;
            if (lat != 4 || out_data !== e) begin errors++; $display("FAIL random_%0d: got lat=%0d data=%h required lat=4 data=%h", k, lat, out_data, e); end
            $display("test_random blk=%0d stall=%0d in=%h out=%h", k, stall, d, out_data);
            out_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_model(8'(i));
        test_reset();
        test_zero();
        test_fips();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_sbox_sweep();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/subbytes_seq.md
# subbytes_seq

Column-serial forward AES SubBytes engine for the encryption datapath; the counterpart of the combinational inverse SubBytes stage on the decryption side. It accepts one 128-bit state over a valid/ready handshake, substitutes one 32-bit column per cycle through four forward S-boxes, and presents the result on a held valid/ready output. It sits between AddRoundKey and MixColumns in the iterative round loop and trades 4× S-box area for 4 cycles of latency.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block accepts `in_data` this cycle.
- `in_data` in 128: input state, column-major. Byte i = 4·col+row sits at bits [127−8i −: 8], so [127:120] is row0/col0.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts `out_data`.
- `out_data` out 128: substituted state, same byte layout.
- `busy` out 1: high in the BUSY state.

## Operation
- Three states: IDLE, BUSY and DONE, plus a 2-bit column counter `col` and a 128-bit state register.
- **IDLE.** `in_ready`=1. When `in_valid` is high, latch `in_data`, set `col`=0 and go to BUSY.
- **BUSY.**
  - Each cycle, replace bits [127−32·col −: 32] with 4 × S-box(byte). Increment `col`.
  - When `col`=3, go to DONE and let `col` wrap to 0.
  - `in_ready`=0. `in_valid` is ignored.
- **DONE.**
  - `out_valid`=1. `out_data` holds stable until `out_valid && out_ready`.
  - On that handshake with `in_valid`=0, go to IDLE.
- **Simultaneous events in DONE.** `in_ready` = IDLE | (DONE & `out_ready`); this is a combinational path from `out_ready`. If `out_ready` and `in_valid` are both high, release the output and accept new data in the same edge, then go directly to BUSY.
- **Held input.** `in_valid` held high while `in_ready`=0 is not consumed. The upstream block must hold `in_data` stable until the handshake.
- **Reset.** Asynchronous assertion at any state, including mid-BUSY, forces:
  - state=IDLE and `col`=0;
  - the state register to 0;
  - `out_valid`=0, `busy`=0 and `out_data`=0.
  
  A partially substituted block is discarded. `in_ready`=1 once reset is deasserted.
- **Width.** Every byte is handled independently; there is no arithmetic beyond the 2-bit counter wrap.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `busy`=0, `out_data`=128'h0.
- Latency: with an accept on edge N, columns 0–3 are written on edges N+1 through N+4, and `out_valid` is high from edge N+4.
- Throughput: one block per 5 cycles with back-to-back handshakes (DONE release and new accept on the same edge). With `out_ready` low, the block stalls indefinitely in DONE.
- No combinational path from `in_data` to outputs. `out_data` is driven directly from a register.

## Configuration
- `SUBBYTES_SHIFTROWS_EN` defined: `out_data` applies ShiftRows to the registered state. Output byte (row r, col c) = state byte (row r, col (c+r) mod 4), which is pure wiring with no added latency.
- Undefined: `out_data` is the plain SubBytes result.
- Handshake, latency and reset behaviour are identical in both builds.

## Structure
- `aes_pkg` holds:
  - `typedef logic [127:0] aes_block_t`;
  - the 3-state `subbytes_state_e` enum;
  - a byte-index helper function (row, col → bit offset) shared with the ShiftRows wiring.
- Sub-module `aes_sbox` is the forward S-box: 8-bit `a` in, 8-bit `c` out, combinational, implemented as a 256-entry case table. Instantiate it four times for the active column, muxing the column by `col`.

## Test plan
- **Reset.** Hold `rst_n`=0. Expect `out_valid`=0, `in_ready`=1, `busy`=0, `out_data`=0.
- **Zero vector.** Accept all-zero `in_data` with `out_ready`=1. Expect `out_valid` exactly 4 cycles later, with `out_data`=128'h63636363_63636363_63636363_63636363.
- **FIPS-197 vector.** Input 193de3be_a0f4e22b_9ac68d2a_e9f84808. Expect d42711ae_e0bf98f1_b8b45de5_1e415230. With `SUBBYTES_SHIFTROWS_EN`, expect d4bf5d30_e0b452ae_b84111f1_1e2798e5.
- **Backpressure.** Hold `out_ready`=0 for 10 cycles in DONE. `out_data` stays stable, `in_ready`=0, and a pending `in_valid` is not consumed. Raising `out_ready` with `in_valid`=1 accepts the next block on the same edge.
- **Back-to-back.** Stream 3 blocks with `in_valid` and `out_ready` tied high. Expect a 5-cycle output spacing and ordered, correct results.
- **Mid-BUSY reset.** Pulse `rst_n` low after column 1 is written. Expect an immediate return to reset values and no `out_valid` for the aborted block. A following accepted block completes correctly.
